dac_reg_spi_tx: RTL and testbench
=================================

DAC_REG_SPI_TX -- requirements
Module: dac_reg_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 4, SCK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CS_SETUP, default 2, clk cycles from chip-select assertion to the first SCK rising edge; legal range 1..255.
REQ-003 Parameter CS_HOLD, default 2, clk cycles from the last SCK falling edge to chip-select deassertion; legal range 1..255.
REQ-004 Port clk, input, 1, the single system clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port start, input, 1, transaction request, sampled only in IDLE.
REQ-007 Port target, input, 1, 0 = DAC (16-bit word on cs1_dac), 1 = register (8-bit word on cs2_reg).
REQ-008 Port tx_data, input, 16, word to send; the register target uses bits [7:0] only.
REQ-009 Port busy, output, 1, high while a transaction is in progress.
REQ-010 Port done, output, 1, one-cycle pulse at the end of a transaction.
REQ-011 Port dac_reg_sck, output, 1, SPI clock, idle low.
REQ-012 Port dac_reg_mosi, output, 1, serial data out, MSB first.
REQ-013 Port cs1_dac, output, 1, DAC chip select, active low.
REQ-014 Port cs2_reg, output, 1, register chip select, active low.
REQ-015 Port dac_reg_miso, input, 1, serial readback data.
REQ-016 Port rx_data, output, 16, readback word.

Function
REQ-017 The state machine SHALL have the states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-018 IDLE with start=1 SHALL latch target and tx_data and enter SETUP on the next cycle; start outside IDLE SHALL be ignored.
REQ-019 On SETUP entry, the selected chip select SHALL go low, the other chip select SHALL stay high, and MOSI SHALL present the MSB (bit 15 for DAC, bit 7 for register).
REQ-020 SETUP SHALL last CS_SETUP cycles with SCK low, then enter SHIFT.
REQ-021 In SHIFT, each bit SHALL take CLK_DIV cycles with SCK low followed by CLK_DIV cycles with SCK high (SPI mode 0).
REQ-022 MOSI SHALL change only on the cycle SCK goes low for the next bit.
REQ-023 The bit count SHALL be 16 for DAC and 8 for register.
REQ-024 After the high phase of the last bit, SCK SHALL return low and the machine SHALL enter HOLD.
REQ-025 HOLD SHALL last CS_HOLD cycles with chip select still low, then enter DONE.
REQ-026 In DONE, both chip selects SHALL be high, done=1, busy=1, and the machine SHALL return to IDLE on the next cycle.
REQ-027 busy SHALL be high from SETUP entry through the DONE cycle inclusive.
REQ-028 A start pulse asserted on the cycle after DONE SHALL begin a new transaction.
REQ-029 A transaction SHALL last 1 + CS_SETUP + 2*CLK_DIV*N + CS_HOLD + 1 cycles from the start cycle to the done cycle inclusive, where N is the bit count.
REQ-030 In IDLE, MOSI SHALL be 0, SCK SHALL be 0, and both chip selects SHALL be 1.
REQ-031 The bit counter and divider SHALL be sized to the maximum parameter values and SHALL NOT wrap within a transaction.

Reset
REQ-032 When rst=1, on the next clock edge: state=IDLE, sck=0, mosi=0, cs1_dac=1, cs2_reg=1, busy=0, done=0, rx_data=0.
REQ-033 A reset mid-transaction SHALL abort the transaction without a done pulse, and chip select SHALL rise immediately.

Configuration
REQ-034 The feature is controlled by the macro DAC_REG_READBACK_EN.
REQ-035 With DAC_REG_READBACK_EN defined, dac_reg_miso SHALL be sampled on every SCK rising-edge cycle and shifted in MSB first.
REQ-036 With DAC_REG_READBACK_EN defined, rx_data SHALL update on the DONE cycle; for the register target the value SHALL be zero-extended.
REQ-037 Without DAC_REG_READBACK_EN, rx_data SHALL be constant 0 and dac_reg_miso SHALL be ignored.

Verification (CLK_DIV=2, CS_SETUP=2, CS_HOLD=2)
REQ-038 DAC write: start with target=0, tx_data=0xA5C3 -> cs1_dac low for 68 cycles, 16 SCK pulses, MOSI bits 1010010111000011, done at cycle 70, cs2_reg high throughout.
REQ-039 Register write: target=1, tx_data=0x123C -> cs2_reg low, 8 SCK pulses, MOSI bits 00111100, done at cycle 38, cs1_dac high throughout.
REQ-040 start held high for the whole transaction -> exactly one transaction; a second start on the cycle after done -> a second transaction begins immediately.
REQ-041 rst=1 at cycle 20 of a DAC write -> next cycle: cs1_dac=1, sck=0, busy=0; no done pulse.
REQ-042 With DAC_REG_READBACK_EN defined and MOSI looped back to MISO, a DAC write of 0xA5C3 -> rx_data=0xA5C3; a register write of 0x3C -> rx_data=0x003C.
REQ-043 Without DAC_REG_READBACK_EN, the same loopback test -> rx_data=0x0000.

Source files
------------

// File: rtl/dac_reg_spi_tx_if.sv
// Request/status and SPI pin bundle for dac_reg_spi_tx.
// master: requester and the SPI-side slave devices; slave: the transmitter.
interface dac_reg_spi_tx_if;
  logic        start;
  logic        target;
  logic [15:0] tx_data;
  logic        busy;
  logic        done;
  logic        dac_reg_sck;
  logic        dac_reg_mosi;
  logic        cs1_dac;
  logic        cs2_reg;
  logic        dac_reg_miso;
  logic [15:0] rx_data;

  modport master (
    output start, target, tx_data, dac_reg_miso,
    input  busy, done, dac_reg_sck, dac_reg_mosi, cs1_dac, cs2_reg, rx_data
  );

  modport slave (
    input  start, target, tx_data, dac_reg_miso,
    output busy, done, dac_reg_sck, dac_reg_mosi, cs1_dac, cs2_reg, rx_data
  );
endinterface

// File: rtl/dac_reg_spi_tx.sv
// SPI mode-0 transmitter: a 16-bit word to the DAC (cs1_dac) or an 8-bit word to a register (cs2_reg).
// Optional MISO readback into rx_data is enabled by defining DAC_REG_READBACK_EN.
module dac_reg_spi_tx #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input logic              clk,
  input logic              rst,
  dac_reg_spi_tx_if.slave  bus
);

  localparam logic [7:0] DivLoad   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SetupLoad = 8'(CS_SETUP - 1);
  localparam logic [7:0] HoldLoad  = 8'(CS_HOLD - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StDone} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_q;
  logic [15:0] shreg_q;
  logic        sck_q;
  logic        mosi_q;
  logic        cs1_q;
  logic        cs2_q;
  logic        busy_q;
  logic        done_q;
  logic        tgt_q;
`ifdef DAC_REG_READBACK_EN
  logic [15:0] rx_sh_q;
  logic [15:0] rx_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs1_q   <= 1'b1;
      cs2_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tgt_q   <= 1'b0;
`ifdef DAC_REG_READBACK_EN
      rx_sh_q <= '0;
      rx_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StSetup;
            tgt_q   <= bus.target;
            busy_q  <= 1'b1;
            cnt_q   <= SetupLoad;
            cs1_q   <= bus.target;
            cs2_q   <= ~bus.target;
            // Register words are left-aligned so MOSI always comes from bit 15.
            if (bus.target) begin
              shreg_q <= {bus.tx_data[7:0], 8'h00};
              mosi_q  <= bus.tx_data[7];
              bit_q   <= 4'd7;
            end else begin
              shreg_q <= bus.tx_data;
              mosi_q  <= bus.tx_data[15];
              bit_q   <= 4'd15;
            end
`ifdef DAC_REG_READBACK_EN
            rx_sh_q <= '0;
`endif
          end
        end
        StSetup: begin
          if (cnt_q == 8'd0) begin
            state_q <= StShift;
            cnt_q   <= DivLoad;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StShift: begin
`ifdef DAC_REG_READBACK_EN
          // First cycle of the SCK high phase.
          if (sck_q && (cnt_q == DivLoad)) begin
            rx_sh_q <= {rx_sh_q[14:0], bus.dac_reg_miso};
          end
`endif
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else if (!sck_q) begin
            sck_q <= 1'b1;
            cnt_q <= DivLoad;
          end else begin
            sck_q <= 1'b0;
            if (bit_q == 4'd0) begin
              state_q <= StHold;
              cnt_q   <= HoldLoad;
            end else begin
              bit_q   <= bit_q - 4'd1;
              cnt_q   <= DivLoad;
              shreg_q <= {shreg_q[14:0], 1'b0};
              mosi_q  <= shreg_q[14];
            end
          end
        end
        StHold: begin
          if (cnt_q == 8'd0) begin
            state_q <= StDone;
            cs1_q   <= 1'b1;
            cs2_q   <= 1'b1;
            done_q  <= 1'b1;
`ifdef DAC_REG_READBACK_EN
            rx_q    <= tgt_q ? {8'h00, rx_sh_q[7:0]} : rx_sh_q;
`endif
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          mosi_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.dac_reg_sck  = sck_q;
  assign bus.dac_reg_mosi = mosi_q;
  assign bus.cs1_dac      = cs1_q;
  assign bus.cs2_reg      = cs2_q;
`ifdef DAC_REG_READBACK_EN
  assign bus.rx_data      = rx_q;
`else
  assign bus.rx_data      = 16'h0000;
`endif

endmodule

// File: tb/tb_dac_reg_spi_tx.sv
// Scoreboard bench for dac_reg_spi_tx with MOSI looped back to MISO.
// Stimulus pushes expected transactions; a negedge monitor checks each one at its done pulse.
module tb_dac_reg_spi_tx;
  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
`ifdef DAC_REG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  dac_reg_spi_tx_if bus ();

  dac_reg_spi_tx #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.dac_reg_miso = bus.dac_reg_mosi;

  typedef struct {
    bit          tgt;
    logic [15:0] data;
    logic [15:0] bits;
    int          n;
    int          len;
    logic [15:0] rx;
  } vec_t;

  typedef struct {
    vec_t v;
    int   start_cyc;
  } exp_t;

  exp_t sb[$];

  // Hand-computed: len = 1 + 2 + 2*2*N + 2 + 1.
  vec_t vecs [4] = '{
    '{tgt: 1'b0, data: 16'hA5C3, bits: 16'hA5C3, n: 16, len: 70, rx: 16'hA5C3},
    '{tgt: 1'b1, data: 16'h123C, bits: 16'h003C, n: 8,  len: 38, rx: 16'h003C},
    '{tgt: 1'b0, data: 16'h0001, bits: 16'h0001, n: 16, len: 70, rx: 16'h0001},
    '{tgt: 1'b1, data: 16'hFF80, bits: 16'h0080, n: 8,  len: 38, rx: 16'h0080}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: collects SPI activity per transaction and checks it at the done pulse.
  initial begin : monitor
    logic [15:0] cap;
    int          pulses, cs1_low, cs2_low;
    logic        sck_prev;
    exp_t        e;
    cap = '0; pulses = 0; cs1_low = 0; cs2_low = 0; sck_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cap = '0; pulses = 0; cs1_low = 0; cs2_low = 0;
      end else begin
        if (!bus.cs1_dac) cs1_low++;
        if (!bus.cs2_reg) cs2_low++;
        if (bus.dac_reg_sck && !sck_prev) begin
          cap = {cap[14:0], bus.dac_reg_mosi};
          pulses++;
        end
        if (bus.done) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1, expected no transaction (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("mosi_bits", 32'(cap), 32'(e.v.bits));
            check("sck_pulses", 32'(pulses), 32'(e.v.n));
            check("cs_sel_low_cycles", 32'(e.v.tgt ? cs2_low : cs1_low), 32'(e.v.len - 2));
            check("cs_other_low_cycles", 32'(e.v.tgt ? cs1_low : cs2_low), 32'd0);
            check("done_cycle", 32'(cyc), 32'(e.start_cyc + e.v.len - 1));
            check("rx_data", 32'(bus.rx_data), 32'(RB ? e.v.rx : 16'h0000));
            check("busy_at_done", 32'(bus.busy), 32'd1);
            check("cs_high_at_done", 32'({bus.cs1_dac, bus.cs2_reg}), 32'd3);
          end
          cap = '0; pulses = 0; cs1_low = 0; cs2_low = 0;
        end
      end
      sck_prev = bus.dac_reg_sck;
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input vec_t v, input bit hold, input bit expect_done);
    exp_t e;
    bus.start   = 1'b1;
    bus.target  = v.tgt;
    bus.tx_data = v.data;
    if (expect_done) begin
      e.v = v;
      e.start_cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; start is dropped there.
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    bus.start = 1'b0;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done, expected done within 300 cycles", name);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int busy_seen;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.target  = 1'b0;
    bus.tx_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sck", 32'(bus.dac_reg_sck), 32'd0);
    check("rst_mosi", 32'(bus.dac_reg_mosi), 32'd0);
    check("rst_cs", 32'({bus.cs1_dac, bus.cs2_reg}), 32'd3);
    check("rst_rx", 32'(bus.rx_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i], 1'b0, 1'b1);
      wait_done("vec");
      repeat (3) @(negedge clk);
    end

    // start held through the whole transaction: only one transaction.
    issue(vecs[0], 1'b1, 1'b1);
    wait_done("hold");
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    check("hold_no_second_txn", 32'(busy_seen), 32'd0);

    // Back-to-back: start on the cycle after done.
    issue(vecs[1], 1'b0, 1'b1);
    wait_done("chain_a");
    @(negedge clk);
    check("idle_after_done_cs", 32'({bus.cs1_dac, bus.cs2_reg}), 32'd3);
    issue(vecs[0], 1'b0, 1'b1);
    check("chain_started_busy", 32'(bus.busy), 32'd1);
    check("chain_started_cs1", 32'(bus.cs1_dac), 32'd0);
    wait_done("chain_b");
    repeat (3) @(negedge clk);

    // Abort with reset during cycle 20 of a DAC write.
    issue(vecs[0], 1'b0, 1'b0);
    repeat (18) @(negedge clk);
    check("pre_abort_cs1", 32'(bus.cs1_dac), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs1", 32'(bus.cs1_dac), 32'd1);
    check("abort_sck", 32'(bus.dac_reg_sck), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_rx", 32'(bus.rx_data), 32'd0);
    repeat (100) @(negedge clk);
    check("abort_pending", 32'(sb.size()), 32'd0);

    // Recovery after abort.
    issue(vecs[1], 1'b0, 1'b1);
    wait_done("recover");
    repeat (3) @(negedge clk);
    check("final_pending", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
